aes_gcm_sequencer: RTL and testbench
====================================

Name: aes_gcm_sequencer

Overview:
Sequences one shared AES core through the request order GCM needs for a single message:
- H = E(K, 0^128), for GHASH.
- E(K, J0), the tag mask.
- N counter blocks E(K, CB_i), delivered as a keystream.
It drives the core's enable/ready/valid handshake and sits between the AES engine and the GCTR/GHASH datapath.

Parameters:
NB_W, 16, width of the block-count input; max message = 2^NB_W - 1 blocks.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_iv  in  96  96-bit IV, captured at accepted start
i_num_blocks  in  NB_W  number of counter blocks, captured at accepted start
i_aes_ready  in  1  AES core idle and able to accept a block
o_aes_en  out  1  one-cycle request strobe to the core
o_aes_block  out  128  block to encrypt; stable from o_aes_en until i_aes_valid
i_aes_valid  in  1  one-cycle result strobe from the core
i_aes_out  in  128  core result, valid with i_aes_valid
o_h  out  128  registered H
o_h_valid  out  1  one-cycle pulse when o_h is updated
o_ek_j0  out  128  registered E(K,J0)
o_ek_j0_valid  out  1  level; high from capture until next accepted start
o_ks  out  128  keystream block
o_ks_valid  out  1  keystream valid; holds until accepted
i_ks_ready  in  1  consumer accepts o_ks when o_ks_valid & i_ks_ready
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse on entering DONE

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counter and block registers 0.
- Reset mid-operation aborts immediately. Any core result arriving later is ignored, because the FSM is in IDLE and does not capture.
- FSM states: IDLE, H_REQ, H_WAIT, J0_REQ, J0_WAIT, CTR_REQ, CTR_WAIT, KS_HOLD, DONE.
- IDLE:
  - i_start=1 → latch IV and N, clear o_ek_j0_valid, go to H_REQ.
  - i_start while not in IDLE is ignored.
- X_REQ states:
  - Drive o_aes_block.
  - Assert o_aes_en for exactly one cycle, in the first cycle i_aes_ready=1; then go to X_WAIT.
  - While i_aes_ready=0, stay and keep o_aes_en=0.
- Request blocks:
  - H_REQ: block 0^128.
  - J0_REQ: block IV||32'h00000001.
  - CTR_REQ: block IV||ctr, where ctr starts at 32'h00000002.
- X_WAIT states: on i_aes_valid, register i_aes_out into the target register. i_aes_valid seen in any non-WAIT state is ignored.
- H_WAIT → J0_REQ; o_h_valid pulses on the cycle after capture.
- J0_WAIT → CTR_REQ if N≠0, otherwise → DONE.
- CTR_WAIT → KS_HOLD; o_ks_valid=1 from the cycle after capture.
- KS_HOLD:
  - o_ks and o_ks_valid stay stable until i_ks_ready.
  - On the accept cycle: o_ks_valid→0, ctr = inc32(ctr), remaining count -1.
  - Then go to DONE if remaining==0, else CTR_REQ.
  - No request is issued to the core while a keystream block is unaccepted (no skid buffer).
- inc32: the low 32 bits increment modulo 2^32 (FFFFFFFF wraps to 00000000); the upper 96 bits are never modified.
- DONE: o_done=1 for one cycle, then IDLE; o_busy=0 from the IDLE cycle.
- Latency with a 0-wait consumer and an L-cycle core (en to valid) is a bound on the path start → o_done.

Optional Feature:
Macro GCM_H_CACHE_EN.
- Defined:
  - Adds input i_h_reuse (1 bit) and an internal flag h_cached, set when H is captured and cleared only by reset.
  - At an accepted start with i_h_reuse=1 and h_cached=1, the FSM goes IDLE→J0_REQ directly. o_h is unchanged and o_h_valid does not pulse.
  - i_h_reuse=1 with h_cached=0 computes H normally.
- Not defined: the port and flag are absent, and H is computed on every start.

Test Plan:
1. Reset mid-run: assert rst_n=0 while in CTR_WAIT → all outputs 0 at once; a later i_aes_valid does not change o_ks or raise o_ks_valid.
2. Basic run: IV=96'hCAFEBABEFACEDBADDECAF888, N=2, core ready, consumer always ready → requests in order: 0^128, IV||00000001, IV||00000002, IV||00000003. Exactly one o_h_valid pulse, two o_ks handshakes, one o_done pulse, busy deasserted afterwards.
3. N=0: → exactly 2 core requests (H and J0); o_ek_j0_valid=1; o_ks_valid never high; o_done pulses.
4. Backpressure: N=3 with i_ks_ready low for 5 cycles on block 1 → o_ks stable and o_ks_valid high throughout; no o_aes_en during the stall; block 2 requested only after the accept.
5. Counter wrap: IV any, low word forced to start at FFFFFFFF through a test hook (N=2 with a preset counter) → second request low word = 00000000, upper 96 bits unchanged.
6. Core busy: i_aes_ready=0 for 4 cycles in H_REQ → o_aes_en=0 during that time, then a single one-cycle pulse. i_start during busy is ignored. With GCM_H_CACHE_EN, a second start with i_h_reuse=1 issues J0 as the first request.

Source files
------------

// File: rtl/aes_gcm_sequencer.sv
// aes_gcm_sequencer: drives one shared AES core through the GCM request
// order for a single message: H = E(K,0), then E(K,J0), then N counter
// blocks E(K,IV||ctr) handed out as a keystream with valid/ready.
// Optional build macro GCM_H_CACHE_EN adds i_h_reuse, which lets a start
// skip the H request once H has been computed since reset.
// CTR_INIT sets the first counter word; it is only overridden to preset the
// counter near its wrap point.
module aes_gcm_sequencer #(
    parameter int unsigned NB_W     = 16,
    parameter logic [31:0] CTR_INIT = 32'h0000_0002
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [95:0]     i_iv,
    input  logic [NB_W-1:0] i_num_blocks,
`ifdef GCM_H_CACHE_EN
    input  logic            i_h_reuse,
`endif
    input  logic            i_aes_ready,
    output logic            o_aes_en,
    output logic [127:0]    o_aes_block,
    input  logic            i_aes_valid,
    input  logic [127:0]    i_aes_out,
    output logic [127:0]    o_h,
    output logic            o_h_valid,
    output logic [127:0]    o_ek_j0,
    output logic            o_ek_j0_valid,
    output logic [127:0]    o_ks,
    output logic            o_ks_valid,
    input  logic            i_ks_ready,
    output logic            o_busy,
    output logic            o_done
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] H_REQ    = 4'd1;
    localparam logic [3:0] H_WAIT   = 4'd2;
    localparam logic [3:0] J0_REQ   = 4'd3;
    localparam logic [3:0] J0_WAIT  = 4'd4;
    localparam logic [3:0] CTR_REQ  = 4'd5;
    localparam logic [3:0] CTR_WAIT = 4'd6;
    localparam logic [3:0] KS_HOLD  = 4'd7;
    localparam logic [3:0] DONE     = 4'd8;

    localparam logic [NB_W-1:0] ONE_BLK = {{(NB_W-1){1'b0}}, 1'b1};

    logic [3:0]      state;
    logic [95:0]     iv_q;
    logic [NB_W-1:0] remaining;
    logic [31:0]     ctr;
    logic            skip_h;

`ifdef GCM_H_CACHE_EN
    logic h_cached;

    // H-cache flag: set on every H capture, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cached <= 1'b0;
        end else if (state == H_WAIT && i_aes_valid) begin
            h_cached <= 1'b1;
        end
    end

    assign skip_h = i_h_reuse & h_cached;
`else
    assign skip_h = 1'b0;
`endif

    assign o_busy = (state != IDLE);

    // Request block and strobe; the block is held through the matching WAIT
    // state, and the strobe fires in the first REQ cycle the core is ready
    always_comb begin
        o_aes_block = '0;
        o_aes_en    = 1'b0;
        case (state)
            H_REQ: begin
                o_aes_en = i_aes_ready;
            end
            J0_REQ: begin
                o_aes_block = {iv_q, 32'h0000_0001};
                o_aes_en    = i_aes_ready;
            end
            J0_WAIT: begin
                o_aes_block = {iv_q, 32'h0000_0001};
            end
            CTR_REQ: begin
                o_aes_block = {iv_q, ctr};
                o_aes_en    = i_aes_ready;
            end
            CTR_WAIT: begin
                o_aes_block = {iv_q, ctr};
            end
            default: begin
                o_aes_block = '0;
                o_aes_en    = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with result capture and keystream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            iv_q          <= '0;
            remaining     <= '0;
            ctr           <= '0;
            o_h           <= '0;
            o_h_valid     <= 1'b0;
            o_ek_j0       <= '0;
            o_ek_j0_valid <= 1'b0;
            o_ks          <= '0;
            o_ks_valid    <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_h_valid <= 1'b0;
            o_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        iv_q          <= i_iv;
                        remaining     <= i_num_blocks;
                        ctr           <= CTR_INIT;
                        o_ek_j0_valid <= 1'b0;
                        state         <= skip_h ? J0_REQ : H_REQ;
                    end
                end
                H_REQ: begin
                    if (i_aes_ready) state <= H_WAIT;
                end
                H_WAIT: begin
                    if (i_aes_valid) begin
                        o_h       <= i_aes_out;
                        o_h_valid <= 1'b1;
                        state     <= J0_REQ;
                    end
                end
                J0_REQ: begin
                    if (i_aes_ready) state <= J0_WAIT;
                end
                J0_WAIT: begin
                    if (i_aes_valid) begin
                        o_ek_j0       <= i_aes_out;
                        o_ek_j0_valid <= 1'b1;
                        if (remaining != '0) begin
                            state <= CTR_REQ;
                        end else begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
                CTR_REQ: begin
                    if (i_aes_ready) state <= CTR_WAIT;
                end
                CTR_WAIT: begin
                    if (i_aes_valid) begin
                        o_ks       <= i_aes_out;
                        o_ks_valid <= 1'b1;
                        state      <= KS_HOLD;
                    end
                end
                KS_HOLD: begin
                    if (i_ks_ready) begin
                        o_ks_valid <= 1'b0;
                        ctr        <= ctr + 32'd1;
                        remaining  <= remaining - ONE_BLK;
                        if (remaining == ONE_BLK) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= CTR_REQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_gcm_sequencer.sv
// tb_aes_gcm_sequencer: table-driven runs of the GCM sequencer against a
// behavioural core stand-in, with request/keystream scoreboards. A second
// instance with the counter preset to FFFFFFFF runs in lockstep on the same
// inputs to exercise the 32-bit counter wrap.
module tb_aes_gcm_sequencer;

    localparam int NB_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_start = 1'b0;
    logic [95:0]     i_iv = '0;
    logic [NB_W-1:0] i_num_blocks = '0;
    logic            i_aes_ready;
    logic            i_aes_valid = 1'b0;
    logic [127:0]    i_aes_out = '0;
    logic            i_ks_ready = 1'b1;
`ifdef GCM_H_CACHE_EN
    logic            h_reuse = 1'b0;
`endif

    logic            o_aes_en, o_h_valid, o_ek_j0_valid, o_ks_valid, o_busy, o_done;
    logic [127:0]    o_aes_block, o_h, o_ek_j0, o_ks;
    logic            w_aes_en, w_h_valid, w_ek_j0_valid, w_ks_valid, w_busy, w_done;
    logic [127:0]    w_aes_block, w_h, w_ek_j0, w_ks;

    always #5 clk = ~clk;

    aes_gcm_sequencer #(.NB_W(NB_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_iv(i_iv),
        .i_num_blocks(i_num_blocks),
`ifdef GCM_H_CACHE_EN
        .i_h_reuse(h_reuse),
`endif
        .i_aes_ready(i_aes_ready), .o_aes_en(o_aes_en), .o_aes_block(o_aes_block),
        .i_aes_valid(i_aes_valid), .i_aes_out(i_aes_out),
        .o_h(o_h), .o_h_valid(o_h_valid), .o_ek_j0(o_ek_j0), .o_ek_j0_valid(o_ek_j0_valid),
        .o_ks(o_ks), .o_ks_valid(o_ks_valid), .i_ks_ready(i_ks_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    aes_gcm_sequencer #(.NB_W(NB_W), .CTR_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_iv(i_iv),
        .i_num_blocks(i_num_blocks),
`ifdef GCM_H_CACHE_EN
        .i_h_reuse(h_reuse),
`endif
        .i_aes_ready(i_aes_ready), .o_aes_en(w_aes_en), .o_aes_block(w_aes_block),
        .i_aes_valid(i_aes_valid), .i_aes_out(i_aes_out),
        .o_h(w_h), .o_h_valid(w_h_valid), .o_ek_j0(w_ek_j0), .o_ek_j0_valid(w_ek_j0_valid),
        .o_ks(w_ks), .o_ks_valid(w_ks_valid), .i_ks_ready(i_ks_ready),
        .o_busy(w_busy), .o_done(w_done)
    );

    logic any_out;
    assign any_out = |{o_aes_en, o_aes_block, o_h, o_h_valid, o_ek_j0, o_ek_j0_valid,
                       o_ks, o_ks_valid, o_busy, o_done,
                       w_aes_en, w_aes_block, w_h, w_h_valid, w_ek_j0, w_ek_j0_valid,
                       w_ks, w_ks_valid, w_busy, w_done};

    int total = 0;
    int bad   = 0;

    // Stand-in cipher: any fixed bijection is enough to tell blocks apart
    function automatic logic [127:0] aes_f(input logic [127:0] b);
        return {b[63:0], b[127:64]} ^ 128'h5A5A_0F0F_C3C3_9696_1234_5678_9ABC_DEF0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboards and event counters
    logic [127:0] req_q[$];
    logic [127:0] wreq_q[$];
    logic [127:0] ks_q[$];
    int n_en, n_hv, n_ks, n_done, n_stall;
    bit ksv_seen;
    bit prev_stall = 1'b0;
    logic [127:0] prev_ks = '0;

    // Core model state
    logic core_idle = 1'b1;
    logic core_hold = 1'b0;
    int   core_lat  = 3;
    assign i_aes_ready = core_idle & ~core_hold;

    // Consumer backpressure control
    int stall_blk  = -1;
    int stall_left = 0;

    // Behavioural AES core: accepts a strobe, answers after core_lat cycles
    initial begin : core
        logic [127:0] blk;
        forever begin
            @(negedge clk);
            if (o_aes_en && rst_n) begin
                blk = o_aes_block;
                @(posedge clk);
                #1 core_idle = 1'b0;
                repeat (core_lat - 1) @(posedge clk);
                #1;
                i_aes_valid = 1'b1;
                i_aes_out   = aes_f(blk);
                @(posedge clk);
                #1;
                i_aes_valid = 1'b0;
                core_idle   = 1'b1;
            end
        end
    end

    // Keystream consumer: holds ready low for stall_left cycles on block stall_blk
    initial begin : consumer
        forever begin
            @(posedge clk);
            #1;
            if (o_ks_valid && n_ks == stall_blk && stall_left > 0) begin
                i_ks_ready = 1'b0;
                stall_left--;
            end else begin
                i_ks_ready = 1'b1;
            end
        end
    end

    // Output monitor: compares requests and keystream against the scoreboards
    always @(negedge clk) begin : mon
        logic [127:0] e;
        if (rst_n) begin
            if (o_aes_en) begin
                n_en++;
                chki("en_needs_ready", int'(i_aes_ready), 1);
                chki("no_req_during_ks", int'(o_ks_valid), 0);
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_req: got %h expected no request", o_aes_block);
                end else begin
                    e = req_q.pop_front();
                    chk("req_block", o_aes_block, e);
                end
            end
            if (w_aes_en) begin
                if (wreq_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wrap_extra_req: got %h expected no request", w_aes_block);
                end else begin
                    e = wreq_q.pop_front();
                    chk("wrap_req_block", w_aes_block, e);
                end
            end
            if (o_h_valid) begin
                n_hv++;
                chk("h_value", o_h, aes_f('0));
            end
            if (o_ks_valid) ksv_seen = 1'b1;
            if (o_ks_valid && i_ks_ready) begin
                n_ks++;
                if (ks_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_ks: got %h expected no keystream", o_ks);
                end else begin
                    e = ks_q.pop_front();
                    chk("ks_block", o_ks, e);
                end
            end
            if (prev_stall) begin
                chki("ks_hold_valid", int'(o_ks_valid), 1);
                chk("ks_hold_data", o_ks, prev_ks);
            end
            prev_stall = o_ks_valid && !i_ks_ready;
            if (prev_stall) begin
                n_stall++;
                prev_ks = o_ks;
            end
            if (o_done) n_done++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        logic [95:0] iv;
        int          n;
        int          lat;
        int          s_blk;
        int          s_cyc;
        int          hold_cyc;
        int          exp_reqs;
        int          exp_ks;
    } vec_t;

    task automatic clear_sb();
        req_q.delete(); wreq_q.delete(); ks_q.delete();
        n_en = 0; n_hv = 0; n_ks = 0; n_done = 0; n_stall = 0; ksv_seen = 1'b0;
    endtask

    // One full message: load scoreboards, start, optionally hold the core, wait for done
    task automatic run(input vec_t v, input bit reuse, input int exp_hv);
        logic [31:0] c;
        clear_sb();
        core_lat   = v.lat;
        stall_blk  = v.s_blk;
        stall_left = v.s_cyc;
        if (!reuse) begin
            req_q.push_back('0);
            wreq_q.push_back('0);
        end
        req_q.push_back({v.iv, 32'h0000_0001});
        wreq_q.push_back({v.iv, 32'h0000_0001});
        for (int i = 0; i < v.n; i++) begin
            c = 32'h0000_0002 + 32'(i);
            req_q.push_back({v.iv, c});
            ks_q.push_back(aes_f({v.iv, c}));
            c = 32'hFFFF_FFFF + 32'(i);
            wreq_q.push_back({v.iv, c});
        end
        @(posedge clk);
        #1;
        i_iv         = v.iv;
        i_num_blocks = NB_W'(v.n);
        i_start      = 1'b1;
`ifdef GCM_H_CACHE_EN
        h_reuse      = reuse;
`endif
        core_hold    = (v.hold_cyc > 0);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < v.hold_cyc; k++) begin
            @(negedge clk);
            chki("busy_core_no_en", int'(o_aes_en), 0);
            chki("busy_flag", int'(o_busy), 1);
            @(posedge clk);
            #1;
            i_start = (k == 1);
            i_iv    = (k == 1) ? ~v.iv : v.iv;
        end
        i_start   = 1'b0;
        core_hold = 1'b0;
        for (int c2 = 0; c2 < 2000 && n_done == 0; c2++) @(negedge clk);
        repeat (2) @(negedge clk);
        chki("n_requests", n_en, v.exp_reqs);
        chki("n_ks", n_ks, v.exp_ks);
        chki("n_h_valid", n_hv, exp_hv);
        chki("n_done", n_done, 1);
        chki("n_stall", n_stall, v.s_cyc);
        chki("ks_valid_seen", int'(ksv_seen), int'(v.exp_ks != 0));
        chki("req_q_drained", req_q.size(), 0);
        chki("busy_after", int'(o_busy), 0);
        chki("ek_j0_valid", int'(o_ek_j0_valid), 1);
        chk("ek_j0_value", o_ek_j0, aes_f({v.iv, 32'h0000_0001}));
`ifdef GCM_H_CACHE_EN
        h_reuse = 1'b0;
`endif
    endtask

    vec_t vecs[4];

    initial begin : main
        vec_t v;
        bit seen;
        vecs[0] = '{96'hCAFEBABEFACEDBADDECAF888, 2, 3, -1, 0, 0, 4, 2};
        vecs[1] = '{96'h0123456789ABCDEF01234567, 0, 3, -1, 0, 0, 2, 0};
        vecs[2] = '{96'hFEEDFACE0BADF00DDEADBEEF, 3, 2,  1, 5, 0, 5, 3};
        vecs[3] = '{96'h13579BDF2468ACE011223344, 5, 1, -1, 0, 0, 7, 5};
        clear_sb();

        // Reset state
        repeat (2) @(negedge clk);
        chki("reset_outputs_zero", int'(any_out), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-run: abort in CTR_WAIT of the second block
        v = '{96'hA5A5A5A5_5A5A5A5A_C0FFEE00, 2, 4, -1, 0, 0, 4, 2};
        clear_sb();
        core_lat = 4;
        req_q.push_back('0);
        req_q.push_back({v.iv, 32'h1});
        req_q.push_back({v.iv, 32'h2});
        req_q.push_back({v.iv, 32'h3});
        wreq_q.push_back('0);
        wreq_q.push_back({v.iv, 32'h1});
        wreq_q.push_back({v.iv, 32'hFFFF_FFFF});
        wreq_q.push_back({v.iv, 32'h0});
        ks_q.push_back(aes_f({v.iv, 32'h2}));
        ks_q.push_back(aes_f({v.iv, 32'h3}));
        @(posedge clk);
        #1;
        i_iv = v.iv; i_num_blocks = 16'd2; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        for (int c = 0; c < 200 && n_en < 4; c++) @(negedge clk);
        chki("rst_reached_ctr_wait", n_en, 4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chki("rst_midrun_outputs_zero", int'(any_out), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_sb();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = i_aes_valid;
        end
        chki("rst_late_valid_seen", int'(seen), 1);
        repeat (2) @(negedge clk);
        chki("rst_late_ks_valid", int'(o_ks_valid), 0);
        chk("rst_late_ks", o_ks, '0);
        chki("rst_late_busy", int'(o_busy), 0);

        // Table-driven message runs
        for (int i = 0; i < 4; i++) run(vecs[i], 1'b0, 1);

        // Core busy for 4 cycles in H_REQ, with a start during busy
        v = '{96'h0F0F0F0F_F0F0F0F0_55AA55AA, 1, 2, -1, 0, 4, 3, 1};
        run(v, 1'b0, 1);

`ifdef GCM_H_CACHE_EN
        // H reuse: J0 is the first request, o_h untouched
        v = '{96'h600DCAFE_BEEF0000_12345678, 1, 2, -1, 0, 0, 2, 1};
        run(v, 1'b1, 0);
        chk("h_unchanged", o_h, aes_f('0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
